// File: rtl/best_match_select.sv
// Minimum-SAD tracker over a 256-candidate search window; emits the winning vector and scaled MAD to the serializer.
// Optional zero-motion bias on candidate (8,8) is enabled with `define ZERO_BIAS_EN.
module best_match_select #(
    parameter int DIST_W    = 16,
    parameter int MAD_SHIFT = 4,
    parameter int SER_LEN   = 20
`ifdef ZERO_BIAS_EN
    ,
    parameter int ZERO_BIAS = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_dist_valid,
    input  logic [DIST_W-1:0] i_dist_in,
    output logic [7:0]        o_coordinate,
    output logic [11:0]       o_mad,
    output logic              o_en_out,
    output logic              o_busy
);

    localparam int DRAIN_W = $clog2(SER_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        EMIT,
        DRAIN
    } state_t;

    state_t              r_state;
    logic [DIST_W-1:0]   r_best_dist;
    logic [7:0]          r_best_xy;
    logic [7:0]          r_cand_cnt;
    logic [DRAIN_W-1:0]  r_drain_cnt;
    logic [7:0]          r_coordinate;
    logic [11:0]         r_mad;
    logic                r_en_out;
    logic                r_busy;

    logic [DIST_W-1:0]   w_eff;
    logic [31:0]         w_shifted;
    logic [11:0]         w_mad_sat;

`ifdef ZERO_BIAS_EN
    localparam logic [DIST_W-1:0] BIAS = DIST_W'(ZERO_BIAS);

    // The zero-motion vector sits at raster index 0x88 in a -8..+7 window.
    always_comb begin
        w_eff = i_dist_in;
        if (r_cand_cnt == 8'h88) begin
            w_eff = (i_dist_in > BIAS) ? (i_dist_in - BIAS) : '0;
        end
    end
`else
    assign w_eff = i_dist_in;
`endif

    // Saturate on any bit of the shifted SAD above bit 11.
    assign w_shifted = 32'(r_best_dist) >> MAD_SHIFT;
    assign w_mad_sat = (w_shifted > 32'd4095) ? 12'hFFF : w_shifted[11:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_best_dist  <= '1;
            r_best_xy    <= '0;
            r_cand_cnt   <= '0;
            r_drain_cnt  <= '0;
            r_coordinate <= '0;
            r_mad        <= '0;
            r_en_out     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_best_dist <= '1;
                        r_best_xy   <= '0;
                        r_cand_cnt  <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (i_dist_valid) begin
                        // Strict compare keeps the earliest candidate on ties.
                        if (w_eff < r_best_dist) begin
                            r_best_dist <= w_eff;
                            r_best_xy   <= {r_cand_cnt[3:0], r_cand_cnt[7:4]};
                        end
                        r_cand_cnt <= r_cand_cnt + 8'd1;
                        if (r_cand_cnt == 8'hFF) begin
                            r_state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    r_en_out     <= 1'b1;
                    r_coordinate <= r_best_xy;
                    r_mad        <= w_mad_sat;
                    r_drain_cnt  <= DRAIN_W'(SER_LEN - 1);
                    r_state      <= DRAIN;
                end
                DRAIN: begin
                    r_en_out <= 1'b0;
                    if (r_drain_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_coordinate = r_coordinate;
    assign o_mad        = r_mad;
    assign o_en_out     = r_en_out;
    assign o_busy       = r_busy;

endmodule
